// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates A/B writebacks onto the register-file write port and tracks pending writes.
// Optional WB_SAME_CYCLE_CLEAR_EN: a register being written this cycle reads as not busy.
module regfile_write_scheduler #(
  parameter int STARVE_LIMIT = 3,
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic        issue_stall,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        rf_write_enable,
  output logic [4:0]  rf_addr_write,
  output logic [31:0] rf_in
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};
  logic [3:0] starve_cnt;
  logic [NUM_REGS-1:0] busy, live, set_vec, clr_vec;
  logic b_prio, a_go, b_go;
  always_comb begin
    b_prio = starve_cnt == LIM;
    a_ready = !reset && !(b_prio && b_valid);
    b_ready = !reset && (b_prio || !a_valid);
    a_go = a_valid && a_ready;
    b_go = b_valid && b_ready;
    rf_addr_write = a_go ? a_addr : b_go ? b_addr : '0;
    rf_in = a_go ? a_data : b_go ? b_data : '0;
    rf_write_enable = (a_go || b_go) && rf_addr_write != '0;
    clr_vec = rf_write_enable ? ONE << rf_addr_write : '0;
`ifdef WB_SAME_CYCLE_CLEAR_EN
    live = busy & ~clr_vec;
`else
    live = busy;
`endif
    issue_stall = !reset && issue_valid && live[issue_addr];
    q_busy1 = !reset && live[q_addr1];
    q_busy2 = !reset && live[q_addr2];
    set_vec = (issue_valid && !issue_stall && issue_addr != '0) ? ONE << issue_addr : '0;
  end
  // set after clear so a same-cycle issue wins over the committing write
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else busy <= (busy & ~clr_vec) | set_vec;
  end
  always_ff @(posedge clk) begin
    if (reset || !b_valid || b_go) starve_cnt <= '0;
    else if (starve_cnt != LIM) starve_cnt <= starve_cnt + 4'd1;
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: scoreboard bench for the register-file write scheduler.
module tb_regfile_write_scheduler;
  logic clk = 0, reset = 1;
  logic a_valid = 0, a_ready, b_valid = 0, b_ready;
  logic [4:0] a_addr = 0, b_addr = 0, issue_addr = 0, q_addr1 = 0, q_addr2 = 0, rf_addr_write;
  logic [31:0] a_data = 0, b_data = 0, rf_in;
  logic issue_valid = 0, issue_stall, q_busy1, q_busy2, rf_write_enable;
  int vectors = 0, errors = 0;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t e;
  regfile_write_scheduler dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_stall(issue_stall),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .rf_write_enable(rf_write_enable), .rf_addr_write(rf_addr_write), .rf_in(rf_in)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    tick;
    reset = 1;
    #2;
    vectors++;
    if ({a_ready, b_ready, rf_write_enable, q_busy1, q_busy2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000", {a_ready, b_ready, rf_write_enable, q_busy1, q_busy2});
    end
    tick;
    reset = 0;
    #2;
    vectors++;
    if ({a_ready, b_ready, rf_write_enable, q_busy1, q_busy2, rf_addr_write, rf_in} !== {5'b11000, 37'd0}) begin
      errors++;
      $display("FAIL idle got ar=%b br=%b we=%b qb=%b%b addr=%0d data=%h", a_ready, b_ready, rf_write_enable, q_busy1, q_busy2, rf_addr_write, rf_in);
    end
  endtask
  task automatic test_issue_write;
    tick;
    issue_valid = 1; issue_addr = 5; q_addr1 = 5;
    #2;
    vectors++;
    if ({issue_stall, q_busy1} !== 2'b00) begin errors++; $display("FAIL issue_r5 got stall=%b busy=%b exp 0 0", issue_stall, q_busy1); end
    tick;
    issue_valid = 0;
    #2;
    vectors++;
    if (q_busy1 !== 1'b1) begin errors++; $display("FAIL busy_r5 got %b exp 1", q_busy1); end
    tick;
    a_valid = 1; a_addr = 5; a_data = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    #2;
    vectors++;
    if (!rf_write_enable) begin errors++; $display("FAIL write_r5 we got 0 exp 1"); end
    else begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : '1;
      if ({rf_addr_write, rf_in} !== e) begin errors++; $display("FAIL write_r5 got %0d:%h exp %0d:%h", rf_addr_write, rf_in, e.a, e.d); end
    end
    vectors++;
`ifdef WB_SAME_CYCLE_CLEAR_EN
    if (q_busy1 !== 1'b0) begin errors++; $display("FAIL busy_during_write got %b exp 0", q_busy1); end
`else
    if (q_busy1 !== 1'b1) begin errors++; $display("FAIL busy_during_write got %b exp 1", q_busy1); end
`endif
    tick;
    a_valid = 0;
    #2;
    vectors++;
    if (q_busy1 !== 1'b0) begin errors++; $display("FAIL busy_after_write got %b exp 0", q_busy1); end
  endtask
  // expect grants A,A,A,B,A when both requesters stay valid from a cleared counter
  task automatic run_contention(input string tag, input logic [4:0] aa, input logic [4:0] ba);
    bit gb [5] = '{0, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      tick;
      a_valid = 1; b_valid = 1; a_addr = aa; b_addr = ba;
      a_data = 32'hA000 + (i < 4 ? i : 3); b_data = 32'hB000;
      exp_q.push_back(gb[i] ? {ba, 32'hB000} : {aa, a_data});
      #2;
      vectors++;
      if ({a_ready, b_ready} !== {!gb[i], gb[i]}) begin
        errors++;
        $display("FAIL %s_ready cycle %0d got ar=%b br=%b exp ar=%b br=%b", tag, i, a_ready, b_ready, !gb[i], gb[i]);
      end
      vectors++;
      e = exp_q.size() != 0 ? exp_q.pop_front() : '1;
      if (!rf_write_enable || {rf_addr_write, rf_in} !== e) begin
        errors++;
        $display("FAIL %s_write cycle %0d got we=%b %0d:%h exp %0d:%h", tag, i, rf_write_enable, rf_addr_write, rf_in, e.a, e.d);
      end
    end
    tick;
    a_valid = 0; b_valid = 0;
  endtask
  task automatic test_contention;
    run_contention("contend", 5'd10, 5'd20);
  endtask
  task automatic test_same_cycle;
    tick;
    issue_valid = 1; issue_addr = 7; q_addr1 = 7;
    a_valid = 1; a_addr = 7; a_data = 32'h77;
    exp_q.push_back({5'd7, 32'h77});
    #2;
    vectors++;
    e = exp_q.size() != 0 ? exp_q.pop_front() : '1;
    if (issue_stall !== 1'b0 || !rf_write_enable || {rf_addr_write, rf_in} !== e) begin
      errors++;
      $display("FAIL same_cycle got stall=%b we=%b %0d:%h exp 0 1 %0d:%h", issue_stall, rf_write_enable, rf_addr_write, rf_in, e.a, e.d);
    end
    tick;
    a_valid = 0;
    #2;
    vectors++;
    if ({issue_stall, q_busy1} !== 2'b11) begin errors++; $display("FAIL issue_wins got stall=%b busy=%b exp 1 1", issue_stall, q_busy1); end
    tick;
    issue_valid = 0;
    #2;
    vectors++;
    if (q_busy1 !== 1'b1) begin errors++; $display("FAIL stall_keeps_busy got %b exp 1", q_busy1); end
    tick;
    a_valid = 1; a_addr = 7; a_data = 32'h78;
    tick;
    a_valid = 0;
    #2;
    vectors++;
    if (q_busy1 !== 1'b0) begin errors++; $display("FAIL r7_cleared got %b exp 0", q_busy1); end
  endtask
  task automatic test_r0;
    tick;
    b_valid = 1; b_addr = 0; b_data = 32'hDEAD;
    #2;
    vectors++;
    if ({b_ready, rf_write_enable} !== 2'b10) begin errors++; $display("FAIL b_r0 got br=%b we=%b exp 1 0", b_ready, rf_write_enable); end
    tick;
    b_valid = 0;
    issue_valid = 1; issue_addr = 0; q_addr2 = 0;
    #2;
    vectors++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL issue_r0 stall got %b exp 0", issue_stall); end
    tick;
    issue_valid = 0;
    #2;
    vectors++;
    if (q_busy2 !== 1'b0) begin errors++; $display("FAIL busy_r0 got %b exp 0", q_busy2); end
  endtask
  task automatic test_reset_mid;
    tick;
    issue_valid = 1; issue_addr = 3;
    tick;
    issue_addr = 9;
    tick;
    issue_valid = 0; q_addr1 = 3; q_addr2 = 9;
    a_valid = 1; b_valid = 1; a_addr = 12; a_data = 32'hC0; b_addr = 13; b_data = 32'hD0;
    exp_q.push_back({5'd12, 32'hC0});
    #2;
    vectors++;
    e = exp_q.size() != 0 ? exp_q.pop_front() : '1;
    if ({q_busy1, q_busy2} !== 2'b11 || {rf_addr_write, rf_in} !== e) begin
      errors++;
      $display("FAIL pre_reset got busy=%b%b %0d:%h exp 11 %0d:%h", q_busy1, q_busy2, rf_addr_write, rf_in, e.a, e.d);
    end
    tick;
    a_data = 32'hC1;
    tick;
    reset = 1;
    #2;
    vectors++;
    if ({a_ready, b_ready, rf_write_enable, q_busy1, q_busy2, issue_stall} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset got %b exp 000000", {a_ready, b_ready, rf_write_enable, q_busy1, q_busy2, issue_stall});
    end
    tick;
    reset = 0; a_valid = 0; b_valid = 0;
    #2;
    vectors++;
    if ({q_busy1, q_busy2} !== 2'b00) begin errors++; $display("FAIL busy_cleared got %b%b exp 00", q_busy1, q_busy2); end
    run_contention("post_reset", 5'd14, 5'd15);
  endtask
  task automatic test_write_clear;
    tick;
    issue_valid = 1; issue_addr = 3; q_addr1 = 3;
    tick;
    issue_valid = 0;
    a_valid = 1; a_addr = 3; a_data = 32'h3333;
    #2;
    vectors++;
`ifdef WB_SAME_CYCLE_CLEAR_EN
    if (q_busy1 !== 1'b0) begin errors++; $display("FAIL bypass_r3 got %b exp 0", q_busy1); end
`else
    if (q_busy1 !== 1'b1) begin errors++; $display("FAIL bypass_r3 got %b exp 1", q_busy1); end
`endif
    tick;
    a_valid = 0;
    #2;
    vectors++;
    if (q_busy1 !== 1'b0) begin errors++; $display("FAIL r3_after got %b exp 0", q_busy1); end
  endtask
  initial begin
    test_reset;
    test_issue_write;
    test_contention;
    test_same_cycle;
    test_r0;
    test_reset_mid;
    test_write_clear;
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
